// File: rtl/pipeline_pkg.sv
// Shared types and constants for the fetch-side pipeline control block.
package pipeline_pkg;

    localparam int unsigned REG_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned ADDR_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational comparator flagging a read-after-write hazard on the ID instruction.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int unsigned FORWARDING = 0,
    parameter int unsigned REG_W      = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_two_src_i,
    input  logic             id_src_valid_i,
    input  logic             ex_wb_en_i,
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic             ex_mem_r_en_i,
    input  logic             mem_wb_en_i,
    input  logic [REG_W-1:0] mem_dest_i,
    output logic             hazard_c
);

    logic ex_hit1_c, ex_hit2_c, mem_hit1_c, mem_hit2_c;
    logic match1_c, match2_c;

    assign ex_hit1_c  = ex_wb_en_i  & (ex_dest_i  == id_src1_i);
    assign ex_hit2_c  = ex_wb_en_i  & (ex_dest_i  == id_src2_i);
    assign mem_hit1_c = mem_wb_en_i & (mem_dest_i == id_src1_i);
    assign mem_hit2_c = mem_wb_en_i & (mem_dest_i == id_src2_i);

    // With a bypass network only a load still in EX cannot be forwarded in time.
    assign match1_c = (FORWARDING != 0) ? (ex_mem_r_en_i & ex_hit1_c) : (ex_hit1_c | mem_hit1_c);
    assign match2_c = (FORWARDING != 0) ? (ex_mem_r_en_i & ex_hit2_c) : (ex_hit2_c | mem_hit2_c);

    assign hazard_c = id_src_valid_i & (match1_c | (id_two_src_i & match2_c));

endmodule

// File: rtl/pipeline_ctrl.sv
// Fetch-side pipeline control: freeze/flush/redirect generation, deferred branch
// redirect across memory stalls, and saturating stall/flush counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned FORWARDING = 0,
    parameter int unsigned REG_W      = REG_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_two_src,
    input  logic              id_src_valid,
    input  logic              ex_wb_en,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic              ex_mem_r_en,
    input  logic              mem_wb_en,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_addr,
    input  logic              mem_busy,
    output logic              freeze,
    output logic              Branch_taken,
    output logic [ADDR_W-1:0] branchAddr,
    output logic              flush,
    output logic              flush_id,
    output logic              id_bubble,
    output logic              freeze_all,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrl_state_t       state_q, state_d;
    logic              pend_br_q, pend_br_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              hazard_c;
    logic              freeze_c, redirect_c, bubble_c, freeze_all_c;
    logic [ADDR_W-1:0] target_c;

    hazard_detect #(
        .FORWARDING (FORWARDING),
        .REG_W      (REG_W)
    ) u_hazard (
        .id_src1_i      (id_src1),
        .id_src2_i      (id_src2),
        .id_two_src_i   (id_two_src),
        .id_src_valid_i (id_src_valid),
        .ex_wb_en_i     (ex_wb_en),
        .ex_dest_i      (ex_dest),
        .ex_mem_r_en_i  (ex_mem_r_en),
        .mem_wb_en_i    (mem_wb_en),
        .mem_dest_i     (mem_dest),
        .hazard_c       (hazard_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            pend_br_q   <= 1'b0;
            pend_addr_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_br_q   <= pend_br_d;
            pend_addr_q <= pend_addr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Priority: memory stall, then branch redirect, then operand hazard.
    always_comb begin
        state_d      = state_q;
        pend_br_d    = pend_br_q;
        pend_addr_d  = pend_addr_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_c     = 1'b0;
        freeze_all_c = 1'b0;
        redirect_c   = 1'b0;
        bubble_c     = 1'b0;
        target_c     = '0;

        case (state_q)
            RUN:      if (mem_busy)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_busy) state_d = RUN;
        endcase

        if (mem_busy) begin
            freeze_c     = 1'b1;
            freeze_all_c = 1'b1;
            if (ex_branch_taken) begin
                pend_br_d   = 1'b1;
                pend_addr_d = ex_branch_addr;
            end
        end else if (ex_branch_taken || pend_br_q) begin
            redirect_c = 1'b1;
            target_c   = pend_br_q ? pend_addr_q : ex_branch_addr;
            pend_br_d  = 1'b0;
            if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (hazard_c) begin
            freeze_c = 1'b1;
            bubble_c = 1'b1;
        end

        if (freeze_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Control outputs are forced low while reset is asserted, whatever the inputs.
    assign freeze       = rst & freeze_c;
    assign freeze_all   = rst & freeze_all_c;
    assign Branch_taken = rst & redirect_c;
    assign flush        = rst & redirect_c;
    assign flush_id     = rst & redirect_c;
    assign id_bubble    = rst & bubble_c;
    assign branchAddr   = (rst && redirect_c) ? target_c : '0;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: one instance without and one with forwarding (narrow counters).
module tb_pipeline_ctrl;

    localparam int unsigned RW  = 4;
    localparam int unsigned CW0 = 16;
    localparam int unsigned CW1 = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_src1, id_src2, ex_dest, mem_dest;
    logic          id_two_src, id_src_valid, ex_wb_en, ex_mem_r_en, mem_wb_en;
    logic          ex_branch_taken, mem_busy;
    logic [31:0]   ex_branch_addr;

    logic          frz [2];
    logic          btk [2];
    logic [31:0]   baddr [2];
    logic          fl [2];
    logic          fli [2];
    logic          bub [2];
    logic          fall [2];
    logic [CW0-1:0] sc0, fc0;
    logic [CW1-1:0] sc1, fc1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.FORWARDING(0), .REG_W(RW), .CNT_W(CW0)) dut0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_src_valid(id_src_valid), .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_mem_r_en(ex_mem_r_en),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .ex_branch_taken(ex_branch_taken),
        .ex_branch_addr(ex_branch_addr), .mem_busy(mem_busy), .freeze(frz[0]), .Branch_taken(btk[0]),
        .branchAddr(baddr[0]), .flush(fl[0]), .flush_id(fli[0]), .id_bubble(bub[0]),
        .freeze_all(fall[0]), .stall_cnt(sc0), .flush_cnt(fc0));

    pipeline_ctrl #(.FORWARDING(1), .REG_W(RW), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_src_valid(id_src_valid), .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_mem_r_en(ex_mem_r_en),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .ex_branch_taken(ex_branch_taken),
        .ex_branch_addr(ex_branch_addr), .mem_busy(mem_busy), .freeze(frz[1]), .Branch_taken(btk[1]),
        .branchAddr(baddr[1]), .flush(fl[1]), .flush_id(fli[1]), .id_bubble(bub[1]),
        .freeze_all(fall[1]), .stall_cnt(sc1), .flush_cnt(fc1));

    typedef struct {
        logic [RW-1:0] s1, s2;
        logic          two, vld, exwb;
        logic [RW-1:0] exd;
        logic          ld, memwb;
        logic [RW-1:0] memd;
        logic          bt;
        logic [31:0]   ba;
        logic          busy;
    } in_t;

    typedef struct {
        logic        frz, bt;
        logic [31:0] addr;
        logic        fl, fli, bub, fall;
    } out_t;

    typedef struct {
        in_t         v;
        logic        frz0, bub0, frz1, bt;
        logic [31:0] addr;
    } vec_t;

    // Reference state: pending redirect and unbounded event counts.
    logic        m_pend;
    logic [31:0] m_paddr;
    int          m_stall [2];
    int          m_flush;

    function automatic in_t mk(int s1, int s2, int two, int vld, int exwb, int exd, int ld,
                               int memwb, int memd, int bt, int ba, int busy);
        in_t v;
        v.s1 = RW'(s1); v.s2 = RW'(s2); v.two = 1'(two); v.vld = 1'(vld);
        v.exwb = 1'(exwb); v.exd = RW'(exd); v.ld = 1'(ld); v.memwb = 1'(memwb);
        v.memd = RW'(memd); v.bt = 1'(bt); v.ba = 32'(ba); v.busy = 1'(busy);
        return v;
    endfunction

    function automatic in_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Does any in-flight writer that cannot be bypassed target register r?
    function automatic bit blocked(int fw, in_t v, logic [RW-1:0] r);
        logic [RW-1:0] writers[$];
        bit hit = 0;
        if (fw != 0) begin
            if (v.ld && v.exwb) writers.push_back(v.exd);
        end else begin
            if (v.exwb)  writers.push_back(v.exd);
            if (v.memwb) writers.push_back(v.memd);
        end
        foreach (writers[k]) if (writers[k] == r) hit = 1;
        return hit;
    endfunction

    function automatic out_t model(int fw, in_t v);
        out_t o;
        bit   haz;
        o = '{default: '0};
        haz = v.vld && (blocked(fw, v, v.s1) || (v.two && blocked(fw, v, v.s2)));
        if (v.busy) begin
            o.frz = 1; o.fall = 1;
        end else if (v.bt || m_pend) begin
            o.bt = 1; o.fl = 1; o.fli = 1;
            o.addr = m_pend ? m_paddr : v.ba;
        end else if (haz) begin
            o.frz = 1; o.bub = 1;
        end
        return o;
    endfunction

    function automatic logic [31:0] sat(int c, int w);
        int mx;
        mx = (1 << w) - 1;
        return 32'((c > mx) ? mx : c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two; id_src_valid = v.vld;
        ex_wb_en = v.exwb; ex_dest = v.exd; ex_mem_r_en = v.ld; mem_wb_en = v.memwb;
        mem_dest = v.memd; ex_branch_taken = v.bt; ex_branch_addr = v.ba; mem_busy = v.busy;
    endtask

    task automatic check_dut(input int i, input out_t e);
        chk($sformatf("d%0d_freeze", i),       32'(frz[i]),  32'(e.frz));
        chk($sformatf("d%0d_branch_taken", i), 32'(btk[i]),  32'(e.bt));
        chk($sformatf("d%0d_branch_addr", i),  baddr[i],     e.addr);
        chk($sformatf("d%0d_flush", i),        32'(fl[i]),   32'(e.fl));
        chk($sformatf("d%0d_flush_id", i),     32'(fli[i]),  32'(e.fli));
        chk($sformatf("d%0d_id_bubble", i),    32'(bub[i]),  32'(e.bub));
        chk($sformatf("d%0d_freeze_all", i),   32'(fall[i]), 32'(e.fall));
    endtask

    // One clock cycle: drive after the edge, check mid-cycle, then advance the model.
    task automatic step(input in_t v, input logic rv);
        out_t e [2];
        @(posedge clk);
        #1;
        drive(v);
        rst = rv;
        if (!rv) begin
            m_pend = 0; m_paddr = '0; m_stall[0] = 0; m_stall[1] = 0; m_flush = 0;
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            if (rv) e[i] = model(i, v);
            else    e[i] = '{default: '0};
            check_dut(i, e[i]);
        end
        chk("d0_stall_cnt", 32'(sc0), sat(m_stall[0], CW0));
        chk("d1_stall_cnt", 32'(sc1), sat(m_stall[1], CW1));
        chk("d0_flush_cnt", 32'(fc0), sat(m_flush, CW0));
        chk("d1_flush_cnt", 32'(fc1), sat(m_flush, CW1));
        if (rv) begin
            if (v.busy) begin
                if (v.bt) begin m_pend = 1; m_paddr = v.ba; end
            end else if (e[0].bt) begin
                m_pend = 0;
            end
            if (e[0].bt) m_flush++;
            for (int i = 0; i < 2; i++) if (e[i].frz) m_stall[i]++;
        end
    endtask

    function automatic in_t rnd_in(input bit busy);
        in_t v;
        v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 1 : 0, 0, busy ? 1 : 0);
        v.ba = $urandom;
        return v;
    endfunction

    vec_t tbl [9];

    initial begin
        int busy_left;
        rst = 1'b0;
        m_pend = 0; m_paddr = '0; m_stall[0] = 0; m_stall[1] = 0; m_flush = 0;
        drive(idle());

        // Reset with random inputs, then release with idle inputs.
        for (int k = 0; k < 3; k++) step(rnd_in($urandom_range(0, 1) == 1), 1'b0);
        step(idle(), 1'b1);
        chk("rst_release_freeze", 32'(frz[0]), 32'd0);
        chk("rst_release_stall_cnt", 32'(sc0), 32'd0);

        //                s1 s2 two vld exwb exd ld mwb md bt ba     busy      frz0 bub0 frz1 bt addr
        tbl[0] = '{mk(3, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0,     0), 1, 1, 0, 0, 32'h0};
        tbl[1] = '{mk(3, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0,     0), 0, 0, 0, 0, 32'h0};
        tbl[2] = '{mk(0, 5, 1, 1, 1, 5, 1, 0, 0, 0, 0,     0), 1, 1, 1, 0, 32'h0};
        tbl[3] = '{mk(0, 5, 1, 1, 1, 5, 0, 0, 0, 0, 0,     0), 1, 1, 0, 0, 32'h0};
        tbl[4] = '{mk(3, 0, 0, 1, 1, 3, 0, 0, 0, 1, 'h40, 0), 0, 0, 0, 1, 32'h40};
        tbl[5] = '{mk(1, 7, 1, 1, 0, 0, 0, 1, 7, 0, 0,     0), 1, 1, 0, 0, 32'h0};
        tbl[6] = '{mk(1, 7, 0, 1, 0, 0, 0, 1, 7, 0, 0,     0), 0, 0, 0, 0, 32'h0};
        tbl[7] = '{mk(3, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0,     0), 0, 0, 0, 0, 32'h0};
        tbl[8] = '{mk(3, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0,     1), 1, 0, 1, 0, 32'h0};
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].v, 1'b1);
            chk($sformatf("vec%0d_freeze0", k), 32'(frz[0]), 32'(tbl[k].frz0));
            chk($sformatf("vec%0d_bubble0", k), 32'(bub[0]), 32'(tbl[k].bub0));
            chk($sformatf("vec%0d_freeze1", k), 32'(frz[1]), 32'(tbl[k].frz1));
            chk($sformatf("vec%0d_btaken", k),  32'(btk[0]), 32'(tbl[k].bt));
            chk($sformatf("vec%0d_baddr", k),   baddr[0],    tbl[k].addr);
        end
        step(idle(), 1'b1);
        chk("tbl_flush_cnt0", 32'(fc0), 32'd1);
        chk("tbl_stall_cnt0", 32'(sc0), 32'd5);
        chk("tbl_stall_cnt1", 32'(sc1), 32'd2);

        // Branch resolved during a 4-cycle memory stall is redirected afterwards.
        for (int k = 1; k <= 4; k++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, (k == 2) ? 1 : 0, 'h100, 1), 1'b1);
            chk($sformatf("memstall%0d_freeze", k),     32'(frz[0]),  32'd1);
            chk($sformatf("memstall%0d_freeze_all", k), 32'(fall[0]), 32'd1);
            chk($sformatf("memstall%0d_btaken", k),     32'(btk[1]),  32'd0);
        end
        step(idle(), 1'b1);
        chk("deferred_btaken", 32'(btk[0]), 32'd1);
        chk("deferred_baddr",  baddr[1],    32'h100);
        step(idle(), 1'b1);
        chk("deferred_cleared", 32'(btk[0]), 32'd0);

        // Reset discards a pending branch.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h200, 1), 1'b1);
        step(idle(), 1'b0);
        step(idle(), 1'b1);
        chk("rst_pend_btaken", 32'(btk[0]), 32'd0);
        chk("rst_pend_flush_cnt", 32'(fc0), 32'd0);
        chk("rst_pend_stall_cnt", 32'(sc1), 32'd0);
        step(idle(), 1'b1);
        chk("rst_pend_btaken2", 32'(btk[1]), 32'd0);

        // Random traffic with memory-busy bursts and occasional resets.
        busy_left = 0;
        for (int k = 0; k < 800; k++) begin
            bit b;
            b = 0;
            if (busy_left > 0) begin
                b = 1; busy_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                busy_left = $urandom_range(1, 5);
            end
            step(rnd_in(b), ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
